// File: rtl/generador_pulso_if.sv
// Purpose: bundles the pulse-train request, operands and status signals.
// Latency: none, wires only.
// Backpressure: none; start is only honoured while the generator is idle.
interface generador_pulso_if #(
   parameter int BIT_periodo = 4,
   parameter int BIT_rep     = 3
);
   logic                   start;
   logic [BIT_periodo-1:0] periodo;
   logic [BIT_periodo-1:0] pausa;
   logic [BIT_rep-1:0]     repeticiones;
   logic                   abort;
   logic                   pulso;
   logic                   busy;
   logic                   done;
   logic [BIT_rep-1:0]     cuenta_pulsos;

   // Requester side: issues trains and watches status.
   modport master (
      output start, periodo, pausa, repeticiones, abort,
      input  pulso, busy, done, cuenta_pulsos
   );

   // Generator side.
   modport slave (
      input  start, periodo, pausa, repeticiones, abort,
      output pulso, busy, done, cuenta_pulsos
   );
endinterface

// File: rtl/generador_pulso.sv
// Purpose: generates a train of N enable pulses, P cycles high with gaps of max(pausa,1) cycles.
// Latency: pulso rises on the edge that accepts start; done strobes on the edge that ends the train.
// Backpressure: start is ignored while busy; abort cuts an active train short on the next edge.
module generador_pulso #(
   parameter int BIT_periodo = 4,
   parameter int BIT_rep     = 3
) (
   input  logic               clk,
   input  logic               rst,
   generador_pulso_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, HIGH, GAP, FIN} state_t;

   localparam logic [BIT_periodo-1:0] CNT_ONE = BIT_periodo'(1);

   state_t                 state_q, state_d;
   logic [BIT_periodo-1:0] per_q, per_d;
   logic [BIT_periodo-1:0] pau_q, pau_d;
   logic [BIT_rep-1:0]     rep_q, rep_d;
   logic [BIT_periodo-1:0] cnt_q, cnt_d;
   logic [BIT_rep-1:0]     cuenta_q, cuenta_d;
   logic                   pulso_q, pulso_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic [BIT_rep-1:0]     rep_last;
   logic                   high_end;
   logic                   gap_end;

   // Phase completion and the count value that marks the last pulse
   // (repeticiones=0 behaves as 1, so its last index is 0 too).
   // cnt_q counts from 1, so it never has to reach 2^BIT_periodo.
   always_comb begin
      rep_last = (rep_q == '0) ? '0 : rep_q - 1'b1;
      high_end = (cnt_q == per_q);
      gap_end  = (cnt_q >= pau_q);
   end

   // Next-state and next-output logic; all outputs are produced from flops.
   always_comb begin
      state_d  = state_q;
      per_d    = per_q;
      pau_d    = pau_q;
      rep_d    = rep_q;
      cnt_d    = cnt_q;
      cuenta_d = cuenta_q;
      pulso_d  = pulso_q;
      busy_d   = busy_q;
      done_d   = done_q;

      case (state_q)
         IDLE: begin
            pulso_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            // abort has no meaning here, so start always wins.
            if (bus.start) begin
               per_d    = bus.periodo;
               pau_d    = bus.pausa;
               rep_d    = bus.repeticiones;
               cuenta_d = '0;
               cnt_d    = CNT_ONE;
               busy_d   = 1'b1;
               if (bus.periodo == '0) begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end else begin
                  state_d = HIGH;
                  pulso_d = 1'b1;
               end
            end
         end

         HIGH: begin
            if (bus.abort) begin
               // Truncated pulse is not counted.
               state_d = FIN;
               pulso_d = 1'b0;
               done_d  = 1'b1;
            end else if (high_end) begin
               pulso_d  = 1'b0;
               cuenta_d = cuenta_q + 1'b1;
               cnt_d    = CNT_ONE;
               if (cuenta_q == rep_last) begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end else begin
                  state_d = GAP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         GAP: begin
            if (bus.abort) begin
               state_d = FIN;
               done_d  = 1'b1;
            end else if (gap_end) begin
               state_d = HIGH;
               pulso_d = 1'b1;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         FIN: begin
            state_d = IDLE;
            done_d  = 1'b0;
            busy_d  = 1'b0;
            pulso_d = 1'b0;
         end

         default: begin
            state_d = IDLE;
            pulso_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   // State register; reset abandons any train immediately with no done strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         per_q    <= '0;
         pau_q    <= '0;
         rep_q    <= '0;
         cnt_q    <= '0;
         cuenta_q <= '0;
         pulso_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         per_q    <= per_d;
         pau_q    <= pau_d;
         rep_q    <= rep_d;
         cnt_q    <= cnt_d;
         cuenta_q <= cuenta_d;
         pulso_q  <= pulso_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.pulso         = pulso_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.cuenta_pulsos = cuenta_q;

endmodule
